// File: rtl/ahb_arbiter_mn.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_mn
//
// Parametrised AHB bus arbiter for P_NUM_MASTERS requesters. Supports a
// fixed-priority (index 0 highest) or round-robin policy, holds the grant for
// the length of fixed-length bursts, and freezes the grant while the owning
// master keeps HLOCK asserted.
//
// Parameters:
//   P_NUM_MASTERS    number of masters (2..16)
//   P_ARB_MODE       0 = fixed priority, 1 = round-robin
//   P_DEFAULT_MASTER master granted when nobody is requesting
//
// Ports:
//   HCLK       bus clock
//   HRESETn    asynchronous active-low reset
//   HREADY     bus-wide ready; all state advances only when high
//   HBUSREQ    per-master bus request
//   HLOCK      per-master locked-transfer request
//   HTRANS     muxed HTRANS of the current HMASTER
//   HBURST     muxed HBURST of the current HMASTER
//   HGRANT     one-hot grant (registered)
//   HMASTER    index of the address-phase owner (registered)
//   HMASTLOCK  current transfer is locked (registered)
// ---------------------------------------------------------------------------
module ahb_arbiter_mn #(
    parameter int P_NUM_MASTERS    = 4,
    parameter int P_ARB_MODE       = 0,
    parameter int P_DEFAULT_MASTER = 0
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HREADY,
    input  logic [P_NUM_MASTERS-1:0] HBUSREQ,
    input  logic [P_NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HBURST,
    output logic [P_NUM_MASTERS-1:0] HGRANT,
    output logic [3:0]               HMASTER,
    output logic                     HMASTLOCK
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [3:0] DEF_IDX = 4'(P_DEFAULT_MASTER);
    localparam logic [P_NUM_MASTERS-1:0] DEF_GRANT =
        {{(P_NUM_MASTERS-1){1'b0}}, 1'b1} << P_DEFAULT_MASTER;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [3:0]                 beat_cnt;
    logic [3:0]                 cnt_next;
    logic [3:0]                 burst_len;
    logic [3:0]                 rr_ptr;
    logic [3:0]                 grant_idx;
    logic [3:0]                 win;
    logic [P_NUM_MASTERS-1:0]   win_onehot;
    logic                       any_req;
    logic                       found;
    logic                       cur_lock;
    logic                       grant_lock;

    // Remaining beats after the NONSEQ beat for fixed-length bursts; SINGLE
    // and undefined-length INCR map to zero so they never hold the grant.
    always_comb begin
        burst_len = 4'd0;
        case (HBURST)
            3'b010, 3'b011: burst_len = 4'd3;
            3'b100, 3'b101: burst_len = 4'd7;
            3'b110, 3'b111: burst_len = 4'd15;
            default:        burst_len = 4'd0;
        endcase
    end

    // Lock bits of the address-phase owner and of the granted master. Loops
    // with constant selects keep the 4-bit index from overrunning the vector
    // when fewer than 16 masters are present.
    always_comb begin
        cur_lock   = 1'b0;
        grant_lock = 1'b0;
        for (int i = 0; i < P_NUM_MASTERS; i++) begin
            if (HMASTER == 4'(i))   cur_lock   = HLOCK[i];
            if (grant_idx == 4'(i)) grant_lock = HLOCK[i];
        end
    end

    // Beat counter tracking. A NONSEQ always (re)starts a burst, so an early
    // termination followed by a new burst is handled in the same cycle; IDLE
    // abandons any burst in progress and BUSY simply pauses it.
    always_comb begin
        cnt_next = beat_cnt;
        case (HTRANS)
            TRANS_IDLE:   cnt_next = 4'd0;
            TRANS_BUSY:   cnt_next = beat_cnt;
            TRANS_NONSEQ: cnt_next = burst_len;
            TRANS_SEQ: begin
                if (state != ST_ARB && beat_cnt != 4'd0)
                    cnt_next = beat_cnt - 4'd1;
            end
            default:      cnt_next = beat_cnt;
        endcase
    end

    // Lock outranks burst tracking; re-arbitration happens only on edges that
    // land back in ARB, which includes the edge accepting the last burst beat.
    always_comb begin
        state_next = ST_ARB;
        if (cur_lock)
            state_next = ST_LOCKED;
        else if (cnt_next != 4'd0)
            state_next = ST_BURST;
    end

    // Arbitration winner. Fixed priority takes the lowest requesting index;
    // round-robin searches upward from just past the pointer and wraps, which
    // also lets a lone requester that already owns the bus keep it.
    always_comb begin
        any_req = |HBUSREQ;
        win     = DEF_IDX;
        found   = 1'b0;
        if (any_req) begin
            if (P_ARB_MODE == 0) begin
                for (int i = P_NUM_MASTERS - 1; i >= 0; i--) begin
                    if (HBUSREQ[i]) win = 4'(i);
                end
            end else begin
                for (int i = 0; i < P_NUM_MASTERS; i++) begin
                    if (!found && HBUSREQ[i] && (4'(i) > rr_ptr)) begin
                        win   = 4'(i);
                        found = 1'b1;
                    end
                end
                for (int i = 0; i < P_NUM_MASTERS; i++) begin
                    if (!found && HBUSREQ[i]) begin
                        win   = 4'(i);
                        found = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < P_NUM_MASTERS; i++) begin
            win_onehot[i] = (win == 4'(i));
        end
    end

    // All arbiter state, including the registered outputs. Nothing moves while
    // HREADY is low. HMASTER follows the grant one accepted address phase late.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_ARB;
            beat_cnt  <= 4'd0;
            rr_ptr    <= DEF_IDX;
            grant_idx <= DEF_IDX;
            HGRANT    <= DEF_GRANT;
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            state     <= state_next;
            beat_cnt  <= cnt_next;
            HMASTER   <= grant_idx;
            HMASTLOCK <= grant_lock;
            if (state_next == ST_ARB) begin
                grant_idx <= win;
                HGRANT    <= win_onehot;
                if (any_req) rr_ptr <= win;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_mn.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter_mn
//
// Directed bench for ahb_arbiter_mn. Two instances share the same inputs: one
// in fixed-priority mode and one in round-robin mode; each scenario checks the
// instance it targets. Expected values are hand-computed per edge.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter_mn;

    localparam int N = 4;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_WRAP8  = 3'b100;

    logic         HCLK;
    logic         HRESETn;
    logic         HREADY;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;

    logic [N-1:0] fix_grant;
    logic [3:0]   fix_master;
    logic         fix_mastlock;
    logic [N-1:0] rr_grant;
    logic [3:0]   rr_master;
    logic         rr_mastlock;

    int compare_count  = 0;
    int mismatch_count = 0;

    ahb_arbiter_mn #(
        .P_NUM_MASTERS   (N),
        .P_ARB_MODE      (0),
        .P_DEFAULT_MASTER(0)
    ) u_fix (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HREADY   (HREADY),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HGRANT   (fix_grant),
        .HMASTER  (fix_master),
        .HMASTLOCK(fix_mastlock)
    );

    ahb_arbiter_mn #(
        .P_NUM_MASTERS   (N),
        .P_ARB_MODE      (1),
        .P_DEFAULT_MASTER(0)
    ) u_rr (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HREADY   (HREADY),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HGRANT   (rr_grant),
        .HMASTER  (rr_master),
        .HMASTLOCK(rr_mastlock)
    );

    // Free-running 10-unit bus clock.
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one set of bus inputs, let one rising edge pass, then settle 1 unit
    // past the edge so outputs are sampled away from the clock.
    task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] lock,
                                 input logic [1:0] trans, input logic [2:0] burst,
                                 input logic ready);
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = trans;
        HBURST  = burst;
        HREADY  = ready;
        @(posedge HCLK);
        #1;
    endtask

    // Pulse reset mid-cycle and check that outputs clear with no clock edge.
    task automatic midCycleReset(input string tag);
        #2;
        HRESETn = 1'b0;
        #1;
        checkOutput({tag, "_grant"},    32'(fix_grant),    32'h1);
        checkOutput({tag, "_master"},   32'(fix_master),   32'h0);
        checkOutput({tag, "_mastlock"}, 32'(fix_mastlock), 32'h0);
        HBUSREQ = '0;
        HLOCK   = '0;
        HTRANS  = T_IDLE;
        HBURST  = B_SINGLE;
        HREADY  = 1'b1;
        #1;
        HRESETn = 1'b1;
    endtask

    // Main directed sequence.
    initial begin
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        HBUSREQ = '0;
        HLOCK   = '0;
        HTRANS  = T_IDLE;
        HBURST  = B_SINGLE;
        #12;
        checkOutput("rst_grant",    32'(fix_grant),    32'h1);
        checkOutput("rst_master",   32'(fix_master),   32'h0);
        checkOutput("rst_mastlock", 32'(fix_mastlock), 32'h0);
        checkOutput("rst_rr_grant", 32'(rr_grant),     32'h1);
        HRESETn = 1'b1;

        // Fixed priority with masters 1 and 3 requesting.
        applyStimulus(4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        checkOutput("fp_grant1",  32'(fix_grant),  32'h2);
        checkOutput("fp_master1", 32'(fix_master), 32'h0);
        applyStimulus(4'b1010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        checkOutput("fp_grant2",  32'(fix_grant),  32'h2);
        checkOutput("fp_master2", 32'(fix_master), 32'h1);
        applyStimulus(4'b1000, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        checkOutput("fp_grant3",  32'(fix_grant),  32'h8);
        checkOutput("fp_master3", 32'(fix_master), 32'h1);
        applyStimulus(4'b1000, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
        checkOutput("fp_master4", 32'(fix_master), 32'h3);

        midCycleReset("async_rst");

        // Round-robin with everybody requesting: grant walks 1,2,3,0,1.
        begin
            logic [N-1:0] rr_exp [5];
            rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
            for (int k = 0; k < 5; k++) begin
                applyStimulus(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
                checkOutput($sformatf("rr_grant%0d", k), 32'(rr_grant), 32'(rr_exp[k]));
            end
        end
        applyStimulus(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b0);
        checkOutput("rr_wait_grant", 32'(rr_grant), 32'h2);

        midCycleReset("async_rst2");

        // Burst hold: master 2 takes the bus, then runs INCR4 with BUSY and a
        // wait state inserted while master 0 is requesting.
        applyStimulus(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        checkOutput("bh_grant_m2", 32'(fix_grant), 32'h4);
        applyStimulus(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        checkOutput("bh_master_m2", 32'(fix_master), 32'h2);
        applyStimulus(4'b0101, 4'b0000, T_NONSEQ, B_INCR4, 1'b1);
        checkOutput("bh_nonseq", 32'(fix_grant), 32'h4);
        applyStimulus(4'b0101, 4'b0000, T_SEQ, B_INCR4, 1'b1);
        checkOutput("bh_seq1", 32'(fix_grant), 32'h4);
        applyStimulus(4'b0101, 4'b0000, T_BUSY, B_INCR4, 1'b1);
        checkOutput("bh_busy", 32'(fix_grant), 32'h4);
        applyStimulus(4'b0101, 4'b0000, T_SEQ, B_INCR4, 1'b0);
        checkOutput("bh_wait_grant",  32'(fix_grant),  32'h4);
        checkOutput("bh_wait_master", 32'(fix_master), 32'h2);
        applyStimulus(4'b0101, 4'b0000, T_SEQ, B_INCR4, 1'b1);
        checkOutput("bh_seq2", 32'(fix_grant), 32'h4);
        applyStimulus(4'b0101, 4'b0000, T_SEQ, B_INCR4, 1'b1);
        checkOutput("bh_seq3_grant",  32'(fix_grant),  32'h1);
        checkOutput("bh_seq3_master", 32'(fix_master), 32'h2);
        applyStimulus(4'b0101, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        checkOutput("bh_handover", 32'(fix_master), 32'h0);

        // Early termination: WRAP8 from master 2 abandoned with IDLE after two
        // beats; grant moves to master 0 on that same edge.
        applyStimulus(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        applyStimulus(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        checkOutput("et_master_m2", 32'(fix_master), 32'h2);
        applyStimulus(4'b0101, 4'b0000, T_NONSEQ, B_WRAP8, 1'b1);
        applyStimulus(4'b0101, 4'b0000, T_SEQ, B_WRAP8, 1'b1);
        checkOutput("et_beat2", 32'(fix_grant), 32'h4);
        applyStimulus(4'b0101, 4'b0000, T_IDLE, B_WRAP8, 1'b1);
        checkOutput("et_abort", 32'(fix_grant), 32'h1);

        // Lock: master 1 locks across two INCR4 bursts while master 0 waits.
        applyStimulus(4'b0010, 4'b0010, T_IDLE, B_SINGLE, 1'b1);
        checkOutput("lk_grant_m1", 32'(fix_grant), 32'h2);
        applyStimulus(4'b0010, 4'b0010, T_IDLE, B_SINGLE, 1'b1);
        checkOutput("lk_master",   32'(fix_master),   32'h1);
        checkOutput("lk_mastlock", 32'(fix_mastlock), 32'h1);
        for (int b = 0; b < 2; b++) begin
            applyStimulus(4'b0011, 4'b0010, T_NONSEQ, B_INCR4, 1'b1);
            for (int s = 0; s < 3; s++) begin
                applyStimulus(4'b0011, 4'b0010, T_SEQ, B_INCR4, 1'b1);
            end
            checkOutput($sformatf("lk_burst%0d_grant", b), 32'(fix_grant), 32'h2);
            checkOutput($sformatf("lk_burst%0d_lock", b), 32'(fix_mastlock), 32'h1);
        end
        applyStimulus(4'b0011, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        checkOutput("lk_release_grant", 32'(fix_grant),    32'h1);
        checkOutput("lk_release_lock",  32'(fix_mastlock), 32'h0);
        applyStimulus(4'b0011, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
        checkOutput("lk_release_master", 32'(fix_master), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_mn.md
Name: ahb_arbiter_mn

Overview:
Parametrised AHB arbiter for the multi-master bus fabric. Generalises the fixed 3-master arbiter to P_NUM_MASTERS requesters. Adds selectable fixed-priority or round-robin policy, burst-aware grant holding with a beat counter, and HLOCK/HMASTLOCK support. It drives the grant vector and HMASTER used by the master-to-slave mux.

Parameters:
P_NUM_MASTERS, 4, number of masters (2..16)
P_ARB_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
P_DEFAULT_MASTER, 0, master granted when no requests are pending (must be < P_NUM_MASTERS)

Ports:
HCLK  input  1  bus clock
HRESETn  input  1  asynchronous active-low reset
HREADY  input  1  bus-wide ready (M_HREADY)
HBUSREQ  input  P_NUM_MASTERS  per-master bus request
HLOCK  input  P_NUM_MASTERS  per-master locked-transfer request
HTRANS  input  2  muxed HTRANS of the current HMASTER
HBURST  input  3  muxed HBURST of the current HMASTER
HGRANT  output  P_NUM_MASTERS  one-hot grant, registered
HMASTER  output  4  index of the master owning the address phase, registered
HMASTLOCK  output  1  current transfer is locked, registered

Behaviour:
- One clock, HCLK. HRESETn is asynchronous and active-low.
- Reset values: HGRANT = one-hot(P_DEFAULT_MASTER); HMASTER = P_DEFAULT_MASTER; HMASTLOCK = 0; state = ARB; beat counter = 0; round-robin pointer = P_DEFAULT_MASTER.
- All state updates only on rising HCLK with HREADY=1. With HREADY=0, every register holds its value.
- HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)] on each HREADY cycle. HMASTER therefore trails HGRANT by one accepted address phase.
- States:
  - ARB: re-arbitration is allowed on each HREADY cycle.
  - BURST: a fixed-length burst is in progress. Grant is frozen.
  - LOCKED: HLOCK[HMASTER]=1. Grant is frozen.
- ARB -> BURST: HTRANS=NONSEQ and HBURST is INCR4/WRAP4, INCR8/WRAP8 or INCR16/WRAP16. The counter loads beats-1 (3, 7 or 15).
- BURST behaviour:
  - HTRANS=SEQ decrements the counter.
  - BUSY holds the counter.
  - IDLE or NONSEQ (early termination, e.g. after ERROR/RETRY) returns to ARB immediately. A NONSEQ also re-evaluates the burst entry condition in the same cycle.
- BURST -> ARB: the edge where the counter goes 1->0. That edge accepts the last beat's address and also performs re-arbitration. The old master then drives IDLE for one cycle before the new HMASTER takes over.
- SINGLE and INCR (undefined length) never enter BURST. Grant may move on any HREADY cycle.
- LOCKED:
  - Entered when HLOCK[HMASTER]=1. HLOCK takes priority over burst completion.
  - Left to ARB (or BURST if the counter is nonzero) when HLOCK[HMASTER]=0.
- Arbitration, when allowed:
  - No HBUSREQ bits set: grant P_DEFAULT_MASTER.
  - Mode 0: grant the lowest set index.
  - Mode 1: grant the first set index strictly after the pointer, searching modulo P_NUM_MASTERS. The pointer <= new granted index.
  - If the current owner is the only requester, it keeps the grant.
- HGRANT is always exactly one-hot. HMASTER is zero-extended to 4 bits.
- Reset asserted mid-burst or mid-lock: immediate return to reset values. No pending state survives.

Test Plan:
- Reset: P_NUM_MASTERS=4, default 0, HRESETn low -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0. HRESETn asserted mid-cycle clears outputs without an HCLK edge.
- Fixed priority: mode 0, HBUSREQ=4'b1010, HREADY=1, SINGLE transfers -> HGRANT=4'b0010 after 1 cycle, HMASTER=1 one cycle later. Dropping HBUSREQ[1] -> HGRANT=4'b1000, HMASTER=3 one cycle after that.
- Round-robin: mode 1, HBUSREQ=4'b1111 held, SINGLE transfers -> grant sequence 1,2,3,0,1 on successive HREADY cycles.
- Burst hold: master 2 owns the bus and issues INCR4 (NONSEQ + 3 SEQ) while HBUSREQ[0]=1 in mode 0 -> HGRANT stays 4'b0100 until the 3rd SEQ edge, then 4'b0001. Insert BUSY and HREADY=0 wait states: the counter and grant freeze throughout.
- Early termination: WRAP8 aborted with IDLE after 2 beats -> ARB re-entered, grant moves to the highest-priority requester on the same edge.
- Lock: master 1 holds HLOCK[1]=1 across two INCR4 bursts with HBUSREQ[0]=1 -> HMASTLOCK=1 and grant stays on master 1 throughout. HLOCK[1] low after the second burst -> grant moves to master 0.
